// File: rtl/mc_databuffer_mc_if.sv
// Write/read port bundle for the multi-channel data buffer.
// The master issues transfers and the buffer (slave) answers with ready/read data.
interface mc_databuffer_mc_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 4
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                  wr_valid;
  logic [CHW-1:0]        wr_ch;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_req;
  logic [CHW-1:0]        rd_ch;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CHW-1:0]        rd_ch_out;

  modport master (
    output wr_valid, wr_ch, wr_data, rd_req, rd_ch,
    input  wr_ready, rd_valid, rd_data, rd_ch_out
  );

  modport slave (
    input  wr_valid, wr_ch, wr_data, rd_req, rd_ch,
    output wr_ready, rd_valid, rd_data, rd_ch_out
  );
endinterface

// File: rtl/mc_databuffer_mc.sv
// NUM_CH independent FIFOs behind one shared write port and one shared read port,
// with per-channel occupancy, threshold flags, flush and sticky error flags.
module mc_databuffer_mc #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int NUM_CH     = 4,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_enable,
  input  logic [NUM_CH-1:0]                    i_flush,
  mc_databuffer_mc_if.slave                    bus,
  output logic [NUM_CH*$clog2(DEPTH+1)-1:0]    o_count,
  output logic [NUM_CH-1:0]                    o_full,
  output logic [NUM_CH-1:0]                    o_empty,
  output logic [NUM_CH-1:0]                    o_almost_full,
  output logic [NUM_CH-1:0]                    o_almost_empty,
  output logic [NUM_CH-1:0]                    o_overflow_err,
  output logic [NUM_CH-1:0]                    o_underflow_err
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0]  AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0]  AE_LVL   = CW'(AE_THRESH);
  localparam logic [CHW:0]   CH_LIM   = (CHW + 1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] r_mem [NUM_CH][DEPTH];
  logic [PW-1:0]         r_wr_ptr [NUM_CH];
  logic [PW-1:0]         r_rd_ptr [NUM_CH];
  logic [CW-1:0]         r_count  [NUM_CH];
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [CHW-1:0]        r_rd_ch_out;
  logic [NUM_CH-1:0]     r_ovf;
  logic [NUM_CH-1:0]     r_unf;

  logic [NUM_CH-1:0]     w_full, w_empty, w_af, w_ae;
  logic [NUM_CH-1:0]     w_inc, w_dec;
  logic                  w_wr_ch_ok, w_rd_ch_ok;
  logic                  w_wr_ready, w_wr_acc, w_rd_acc;

  // Status flags and acceptance look only at pre-edge counts, so a read never
  // frees space for a same-cycle write and a write never bypasses to a read.
  always_comb begin
    o_count = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_full[c]  = (r_count[c] == FULL_LVL);
      w_empty[c] = (r_count[c] == '0);
      w_af[c]    = (r_count[c] >= AF_LVL);
      w_ae[c]    = (r_count[c] <= AE_LVL);
      o_count[c*CW +: CW] = r_count[c];
    end
    w_wr_ch_ok = ({1'b0, bus.wr_ch} < CH_LIM);
    w_rd_ch_ok = ({1'b0, bus.rd_ch} < CH_LIM);
    w_wr_ready = i_enable && w_wr_ch_ok && !w_full[bus.wr_ch] && !i_flush[bus.wr_ch];
    w_wr_acc   = bus.wr_valid && w_wr_ready;
    w_rd_acc   = i_enable && bus.rd_req && w_rd_ch_ok &&
                 !w_empty[bus.rd_ch] && !i_flush[bus.rd_ch];
    for (int c = 0; c < NUM_CH; c++) begin
      w_inc[c] = w_wr_acc && (bus.wr_ch == CHW'(c));
      w_dec[c] = w_rd_acc && (bus.rd_ch == CHW'(c));
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[bus.wr_ch][r_wr_ptr[bus.wr_ch]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_ch_out <= '0;
      r_ovf       <= '0;
      r_unf       <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_wr_ptr[c] <= '0;
        r_rd_ptr[c] <= '0;
        r_count[c]  <= '0;
      end
    end else if (i_enable) begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data   <= r_mem[bus.rd_ch][r_rd_ptr[bus.rd_ch]];
        r_rd_ch_out <= bus.rd_ch;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (i_flush[c]) begin
          r_wr_ptr[c] <= '0;
          r_rd_ptr[c] <= '0;
          r_count[c]  <= '0;
        end else begin
          if (w_inc[c]) r_wr_ptr[c] <= r_wr_ptr[c] + PW'(1);
          if (w_dec[c]) r_rd_ptr[c] <= r_rd_ptr[c] + PW'(1);
          r_count[c] <= r_count[c] + CW'(w_inc[c]) - CW'(w_dec[c]);
        end
        // Errors are sticky and survive flush; only reset clears them.
        if (bus.wr_valid && (bus.wr_ch == CHW'(c)) && w_full[c])  r_ovf[c] <= 1'b1;
        if (bus.rd_req   && (bus.rd_ch == CHW'(c)) && w_empty[c]) r_unf[c] <= 1'b1;
      end
    end
  end

  assign bus.wr_ready     = w_wr_ready;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_ch_out    = r_rd_ch_out;
  assign o_full           = w_full;
  assign o_empty          = w_empty;
  assign o_almost_full    = w_af;
  assign o_almost_empty   = w_ae;
  assign o_overflow_err   = r_ovf;
  assign o_underflow_err  = r_unf;
endmodule

// File: doc/mc_databuffer_mc.md
# mc_databuffer_mc

Multi-channel data buffer for the memory-controller datapath: NUM_CH independent FIFOs share one clock and one write and one read port, with channel selected per transfer. It sits between the command scheduler and the PHY data path, buffering per-bank/per-port write or read data. It adds four things to the single-channel buffer:

- per-channel occupancy counts
- programmable almost-full/almost-empty flags
- correct same-cycle read+write accounting
- per-channel flush and sticky error flags

## Interface
- DATA_WIDTH, 64: width of each data word.
- DEPTH, 16: entries per channel; power of two, ≥ 2.
- NUM_CH, 4: number of channels, ≥ 1. CHW = max(1, $clog2(NUM_CH)).
- AF_THRESH, DEPTH-4: almost_full[c] asserts when count[c] ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty[c] asserts when count[c] ≤ AE_THRESH.
- Count width: CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global advance; when low, no state changes and wr_ready is 0.
- flush  in  NUM_CH  per-channel clear, one bit per channel.
- wr_valid  in  1  write request.
- wr_ch  in  CHW  target channel of the write.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  combinational: enable && !full[wr_ch] && !flush[wr_ch].
- rd_req  in  1  read request.
- rd_ch  in  CHW  source channel of the read.
- rd_valid  out  1  registered; rd_data/rd_ch_out valid this cycle.
- rd_data  out  DATA_WIDTH  registered read word.
- rd_ch_out  out  CHW  channel the rd_data came from.
- count  out  NUM_CH*CW  occupancy, channel c at [c*CW +: CW].
- full, empty, almost_full, almost_empty  out  NUM_CH each  status per channel, decoded from count.
- overflow_err, underflow_err  out  NUM_CH each  sticky error flags.

## Operation
- Storage: NUM_CH×DEPTH words. Each channel has its own wr_ptr, rd_ptr (log2(DEPTH) bits) and count (CW bits). Pointers wrap modulo DEPTH naturally.
- Write accepted when wr_valid && wr_ready: store at wr_ptr[wr_ch], increment wr_ptr and count.
- Read accepted when enable && rd_req && !empty[rd_ch] && !flush[rd_ch]:
  - rd_data <= mem[rd_ch][rd_ptr]
  - increment rd_ptr, decrement count
  - rd_valid <= 1, rd_ch_out <= rd_ch.
- When no read is accepted on an enabled cycle, rd_valid <= 0; rd_data and rd_ch_out hold their values.
- Same-cycle write and read, same channel: both accepted if each is individually legal; count unchanged.
- Acceptance is decided on pre-edge state only:
  - No write into a full channel, even with a simultaneous read of it.
  - No read of an empty channel, even with a simultaneous write to it (no bypass).
- Different channels: independent, both may be accepted in the same cycle.
- Flush[c] (when enable): pointers and count of c go to 0, and it overrides any read/write to c that cycle. Other channels are unaffected.
- Errors:
  - overflow_err[c] sets when wr_valid with wr_ch=c while full[c] and enable.
  - underflow_err[c] sets when rd_req with rd_ch=c while empty[c] and enable.
  - Both are sticky until reset; flush does not clear them.
- enable low: all registers hold, including rd_valid. Requests are ignored and set no errors.
- Status flags are combinational decodes of the count registers:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full / almost_empty per the thresholds.

## Timing
- Reset (synchronous, dominates everything, including enable and flush):
  - all pointers and counts 0
  - rd_valid 0, rd_data 0, rd_ch_out 0
  - full 0, almost_full 0 (AF_THRESH ≥ 1)
  - empty all 1, almost_empty all 1
  - errors 0.
- Reset mid-operation discards all contents; the first cycle after reset behaves as post-reset.
- Read latency: 1 cycle; rd_valid/rd_data appear on the cycle after the accepting edge.
- Write-to-read: a word written at edge N is readable by a request sampled at edge N+1, with data out after edge N+1.
- Count and all flags reflect an accepted operation immediately after its edge.
- Full throughput: one write and one read per cycle sustained.

## Test plan
- Reset, then check outputs: empty=4'b1111, almost_empty=4'b1111, count=0, rd_valid=0, wr_ready=1.
- Write 16 words (0x0..0xF) to ch2 -> full[2]=1, wr_ready=0 with wr_ch=2, almost_full[2] asserted from count 12. A 17th write sets overflow_err[2] and count stays 16. Read all 16 -> data 0x0..0xF in order, empty[2]=1, pointers wrapped.
- ch0 at count 5, simultaneous write 0xAA and read -> count stays 5, rd_valid next cycle with the oldest word. Write ch1 + read ch3 in the same cycle -> independent.
- ch0 full, same-cycle write+read -> write rejected, read accepted, count 15. ch1 empty, same-cycle write+read -> read rejected, underflow_err[1]=1, count 1.
- ch3 at count 7, flush[3] with simultaneous write to ch3 -> count[3]=0, empty[3]=1, other channels unchanged, errors retained.
- enable=0 for 3 cycles with requests toggling -> no count/pointer/error change, rd_valid held. Assert reset mid-burst -> all outputs return to reset values on the next edge.
